// File: rtl/run_ctrl_if.sv
// Handshake bundle between the launch bench/decoder side and the run controller.
// The master drives launch/halt requests; the slave (run_ctrl) drives status and PC-load controls.
interface run_ctrl_if #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
);
   logic             start;
   logic             halt;
   logic             ack;
   logic             run_en;
   logic             pc_load;
   logic [PC_W-1:0]  pc_load_addr;
   logic [1:0]       prog_idx;
   logic [CNT_W-1:0] cycle_count;
   logic             timeout;

   modport master (
      output start, halt,
      input  ack, run_en, pc_load, pc_load_addr, prog_idx, cycle_count, timeout
   );

   modport slave (
      input  start, halt,
      output ack, run_en, pc_load, pc_load_addr, prog_idx, cycle_count, timeout
   );
endinterface

// File: rtl/run_ctrl.sv
// Program-launch controller: arms on a Start high-then-low sequence, loads the PC with the
// next program's base, runs until Halt or the cycle limit, then reports completion.
module run_ctrl #(
   parameter int               PC_W    = 10,
   parameter int               CNT_W   = 16,
   parameter logic [PC_W-1:0]  P1_BASE = '0,
   parameter logic [PC_W-1:0]  P2_BASE = 10'h100,
   parameter logic [PC_W-1:0]  P3_BASE = 10'h200,
   parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFF0
) (
   input logic        clk,
   input logic        rst,
   run_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      LOAD  = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state;
   logic             ack;
   logic             run_en;
   logic             pc_load;
   logic             timeout;
   logic [1:0]       prog_idx;
   logic [CNT_W-1:0] cycle_count;
   logic [PC_W-1:0]  pc_load_addr;

   logic [1:0]       idx_next;
   logic [CNT_W-1:0] count_inc;
   logic             limit_hit;

   function automatic logic [PC_W-1:0] base_of(input logic [1:0] idx);
      case (idx)
         2'd1:    return P2_BASE;
         2'd2:    return P3_BASE;
         default: return P1_BASE;
      endcase
   endfunction

   assign idx_next  = (prog_idx == 2'd2) ? 2'd0 : prog_idx + 2'd1;
   assign count_inc = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
   assign limit_hit = (cycle_count == TIMEOUT);

   // Outputs are registered alongside the state so each reflects the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ack          <= 1'b0;
         run_en       <= 1'b0;
         pc_load      <= 1'b0;
         timeout      <= 1'b0;
         prog_idx     <= 2'd0;
         cycle_count  <= '0;
         pc_load_addr <= P1_BASE;
      end else begin
         ack     <= 1'b0;
         run_en  <= 1'b0;
         pc_load <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) state <= ARMED;
            end
            ARMED: begin
               if (!bus.start) begin
                  state       <= LOAD;
                  pc_load     <= 1'b1;
                  timeout     <= 1'b0;
                  cycle_count <= '0;
               end
            end
            LOAD: begin
               state  <= RUN;
               run_en <= 1'b1;
            end
            RUN: begin
               // Halt wins over a simultaneous limit hit and still counts its own cycle.
               if (bus.halt) begin
                  state        <= DONE;
                  ack          <= 1'b1;
                  cycle_count  <= count_inc;
                  timeout      <= 1'b0;
                  prog_idx     <= idx_next;
                  pc_load_addr <= base_of(idx_next);
               end else if (limit_hit) begin
                  state        <= DONE;
                  ack          <= 1'b1;
                  timeout      <= 1'b1;
                  prog_idx     <= idx_next;
                  pc_load_addr <= base_of(idx_next);
               end else begin
                  run_en      <= 1'b1;
                  cycle_count <= count_inc;
               end
            end
            DONE: begin
               if (bus.start) state <= ARMED;
               else           ack   <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack          = ack;
   assign bus.run_en       = run_en;
   assign bus.pc_load      = pc_load;
   assign bus.pc_load_addr = pc_load_addr;
   assign bus.prog_idx     = prog_idx;
   assign bus.cycle_count  = cycle_count;
   assign bus.timeout      = timeout;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: one default instance and one with an 8-cycle limit.
module tb_run_ctrl;

    localparam int TIMEOUT_A = 32'hFFF0;
    localparam int TIMEOUT_B = 8;

    logic clk;
    logic rst;

    run_ctrl_if bus_a();
    run_ctrl_if bus_b();

    run_ctrl u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    run_ctrl #(.TIMEOUT(16'd8)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        logic        ack;
        logic        run_en;
        logic        pc_load;
        logic [9:0]  addr;
        logic [1:0]  idx;
        logic [15:0] count;
        logic        timeout;
    } obs_t;

    typedef struct {
        int sel;
        int addr;
        int count;
        int idx;
        int timeout;
        int cycles;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   idx_a = 0;
    int   idx_b = 0;
    bit   done_a = 0;
    bit   done_b = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t get_obs(input bit sel);
        obs_t o;
        if (sel) begin
            o.ack = bus_b.ack; o.run_en = bus_b.run_en; o.pc_load = bus_b.pc_load;
            o.addr = bus_b.pc_load_addr; o.idx = bus_b.prog_idx;
            o.count = bus_b.cycle_count; o.timeout = bus_b.timeout;
        end else begin
            o.ack = bus_a.ack; o.run_en = bus_a.run_en; o.pc_load = bus_a.pc_load;
            o.addr = bus_a.pc_load_addr; o.idx = bus_a.prog_idx;
            o.count = bus_a.cycle_count; o.timeout = bus_a.timeout;
        end
        return o;
    endfunction

    function automatic int base_of(input int i);
        case (i)
            1:       return 32'h100;
            2:       return 32'h200;
            default: return 0;
        endcase
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus_b.start = v; else bus_a.start = v;
    endtask

    task automatic set_halt(input bit sel, input logic v);
        if (sel) bus_b.halt = v; else bus_a.halt = v;
    endtask

    // Launch one program: Start high for `hold` cycles, then low; Halt on RUN cycle `halt_at` (0 = never).
    task automatic run_prog(input bit sel, input int hold, input int halt_at);
        exp_t e;
        obs_t o;
        int   idx_m;
        int   lim;
        int   k;
        int   seen;
        bit   was_done;

        idx_m    = sel ? idx_b : idx_a;
        lim      = sel ? TIMEOUT_B : TIMEOUT_A;
        was_done = sel ? done_b : done_a;
        e.sel  = sel;
        e.addr = base_of(idx_m);
        e.idx  = (idx_m + 1) % 3;
        if (halt_at >= 1 && halt_at <= lim + 1) begin
            e.count = halt_at; e.timeout = 0; e.cycles = halt_at;
        end else begin
            e.count = lim; e.timeout = 1; e.cycles = lim + 1;
        end
        sb_q.push_back(e);
        if (sel) idx_b = e.idx; else idx_a = e.idx;

        @(negedge clk);
        if (was_done) begin
            o = get_obs(sel);
            check("ack_hold", 32'(o.ack), 1);
        end
        set_start(sel, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            o = get_obs(sel);
            check("armed_ack", 32'(o.ack), 0);
            check("armed_pcload", 32'(o.pc_load), 0);
        end
        set_start(sel, 1'b0);
        @(negedge clk);
        o = get_obs(sel);
        check("load_pulse", 32'(o.pc_load), 1);
        check("load_addr", 32'(o.addr), e.addr);
        check("load_runen", 32'(o.run_en), 0);
        check("load_count", 32'(o.count), 0);
        check("load_timeout", 32'(o.timeout), 0);
        @(negedge clk);
        o = get_obs(sel);
        check("run_pcload", 32'(o.pc_load), 0);
        check("run_runen", 32'(o.run_en), 1);

        k = 1;
        seen = 0;
        while (k <= 200) begin
            o = get_obs(sel);
            if (o.ack) break;
            if (o.run_en) seen++;
            if (k == halt_at) set_halt(sel, 1'b1);
            @(negedge clk);
            set_halt(sel, 1'b0);
            k++;
        end
        check("ack_seen", 32'(o.ack), 1);

        e = sb_q.pop_front();
        check("done_runen", 32'(o.run_en), 0);
        check("done_count", 32'(o.count), e.count);
        check("done_idx", 32'(o.idx), e.idx);
        check("done_timeout", 32'(o.timeout), e.timeout);
        check("run_cycles", seen, e.cycles);
        $display("[%0t] dut%0d addr=%03h count=%0d idx=%0d timeout=%0b run_cycles=%0d",
                 $time, e.sel, e.addr, o.count, o.idx, o.timeout, seen);
        if (sel) done_b = 1; else done_a = 1;
    endtask

    initial begin
        obs_t o;
        rst = 1'b0;
        bus_a.start = 1'b0; bus_a.halt = 1'b0;
        bus_b.start = 1'b0; bus_b.halt = 1'b0;
        #2 rst = 1'b1;
        #1;
        o = get_obs(0);
        check("rst_ack", 32'(o.ack), 0);
        check("rst_runen", 32'(o.run_en), 0);
        check("rst_pcload", 32'(o.pc_load), 0);
        check("rst_addr", 32'(o.addr), 0);
        check("rst_idx", 32'(o.idx), 0);
        check("rst_count", 32'(o.count), 0);
        check("rst_timeout", 32'(o.timeout), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Halt while idle must be ignored.
        bus_a.halt = 1'b1;
        @(negedge clk);
        bus_a.halt = 1'b0;
        @(negedge clk);
        o = get_obs(0);
        check("idle_halt_ack", 32'(o.ack), 0);
        check("idle_halt_idx", 32'(o.idx), 0);
        check("idle_halt_pcload", 32'(o.pc_load), 0);
        $display("[%0t] dut0 idle halt pulse ack=%0b idx=%0d", $time, o.ack, o.idx);

        run_prog(0, 1, 20);
        run_prog(0, 1, 5);
        run_prog(0, 1, 3);
        run_prog(0, 5, 2);

        run_prog(1, 1, 0);
        run_prog(1, 1, 9);
        run_prog(1, 2, 4);

        // Abort a program mid-RUN with an asynchronous reset pulse.
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (4) @(negedge clk);
        o = get_obs(0);
        check("pre_abort_runen", 32'(o.run_en), 1);
        #2 rst = 1'b1;
        #1;
        o = get_obs(0);
        check("abort_runen", 32'(o.run_en), 0);
        check("abort_ack", 32'(o.ack), 0);
        check("abort_idx", 32'(o.idx), 0);
        check("abort_count", 32'(o.count), 0);
        check("abort_addr", 32'(o.addr), 0);
        o = get_obs(1);
        check("abort_ack_b", 32'(o.ack), 0);
        $display("[%0t] dut0 reset mid-run runen=%0b ack=%0b", $time, o.run_en, o.ack);
        @(negedge clk);
        rst = 1'b0;
        idx_a = 0; idx_b = 0; done_a = 0; done_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            o = get_obs(0);
            check("post_abort_ack", 32'(o.ack), 0);
            check("post_abort_runen", 32'(o.run_en), 0);
        end
        run_prog(0, 1, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter PC_W, default 10: instruction-address width.
REQ-002 Parameter CNT_W, default 16: cycle-counter width.
REQ-003 Parameter P1_BASE, default 0: start address of program 1.
REQ-004 Parameter P2_BASE, default 10'h100: start address of program 2.
REQ-005 Parameter P3_BASE, default 10'h200: start address of program 3.
REQ-006 Parameter TIMEOUT, default 16'hFFF0: run-cycle limit that forces completion.
REQ-007 Clk  input  1  system clock, rising edge active.
REQ-008 Reset  input  1  asynchronous, active-high reset.
REQ-009 Start  input  1  launch request from the bench; a high-then-low sequence launches the next program.
REQ-010 Halt  input  1  from decoder: the done instruction is executing.
REQ-011 Ack  output  1  done flag to the bench.
REQ-012 RunEn  output  1  enables PC advance and all architectural writes.
REQ-013 PcLoad  output  1  one-cycle pulse: PC loads PcLoadAddr.
REQ-014 PcLoadAddr  output  PC_W  base address of the program being launched.
REQ-015 ProgIdx  output  2  index of the next or current program (0..2).
REQ-016 CycleCount  output  CNT_W  RUN cycles of the current or last program.
REQ-017 Timeout  output  1  last run ended on TIMEOUT, not on Halt.

Function
REQ-018 FSM states are IDLE, ARMED, LOAD, RUN, DONE, all registered, one transition per Clk edge.
REQ-019 IDLE/DONE: Start sampled high -> ARMED; otherwise hold.
REQ-020 ARMED: Start sampled low -> LOAD; Start high -> hold.
REQ-021 LOAD lasts exactly one cycle, then RUN.
REQ-022 RUN: Halt sampled high, or CycleCount == TIMEOUT, -> DONE; otherwise hold.
REQ-023 Ack = 1 only in DONE (Moore); it drops in the cycle after Start is sampled high.
REQ-024 RunEn = 1 only in RUN; PcLoad = 1 only in LOAD.
REQ-025 PcLoadAddr = P1_BASE/P2_BASE/P3_BASE for ProgIdx 0/1/2.
REQ-026 CycleCount clears to 0 on the LOAD cycle.
REQ-027 CycleCount increments by 1 each RUN cycle, including the cycle in which Halt is sampled.
REQ-028 CycleCount holds its value in DONE, IDLE and ARMED.
REQ-029 CycleCount saturates at all-ones and never wraps.
REQ-030 On the RUN->DONE edge, ProgIdx increments with wrap (2 -> 0).
REQ-031 On the RUN->DONE edge, Timeout is set to 1 if the exit was caused by the limit and Halt was low, else 0.
REQ-032 Timeout clears on entry to LOAD.
REQ-033 Halt and the limit reached in the same cycle: treated as Halt, Timeout = 0.
REQ-034 Halt outside RUN is ignored; Start changes during LOAD/RUN are ignored.
REQ-035 Latency: Start sampled low in ARMED at edge N -> PcLoad high after edge N, RunEn high after edge N+1.
REQ-036 Latency: Halt sampled at edge M -> Ack high and RunEn low after edge M.

Reset
REQ-037 Reset high forces state IDLE immediately, independent of Clk.
REQ-038 Reset high drives Ack, RunEn, PcLoad, Timeout, ProgIdx, CycleCount to 0 and PcLoadAddr to P1_BASE.
REQ-039 Reset asserted mid-RUN aborts the program; no DONE or Ack follows.
REQ-040 After Reset releases, the FSM waits in IDLE for a new Start sequence.

Verification
REQ-041 Reset; Start high 1 cycle then low; Halt asserted on the 20th RUN cycle -> PcLoad one pulse with PcLoadAddr 0, Ack=1, CycleCount=20, ProgIdx=1, Timeout=0.
REQ-042 Three back-to-back launches, Start raised 1 cycle after each Ack -> PcLoadAddr 0x000, 0x100, 0x200; Ack falls 1 cycle after each Start rise; ProgIdx wraps to 0.
REQ-043 TIMEOUT=8, Halt never asserted -> DONE after 9 RUN cycles (count reaches 8, then exits), CycleCount=8, Timeout=1, Ack=1.
REQ-044 TIMEOUT=8, Halt asserted in the cycle the count equals 8 -> Timeout=0, CycleCount=9.
REQ-045 Reset pulse mid-RUN (between edges) -> RunEn and Ack 0 immediately, ProgIdx=0, CycleCount=0; no Ack until the next full Start sequence.
REQ-046 Start held high 5 cycles in ARMED, plus a Halt pulse in IDLE -> no PcLoad until Start falls; the Halt has no effect.
